// File: rtl/cpu_debug_cmd_scheduler_if.sv
// Shared on-chip debug register bus: one outstanding req/ack transaction.
// The scheduler drives the master side; the debug register file answers as slave.
interface cpu_debug_cmd_scheduler_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, output we, output sel, output addr, output wdata,
                    input  ack, input  rdata);
    modport slave  (input  req, input  we, input  sel, input  addr, input  wdata,
                    output ack, output rdata);
endinterface

// File: rtl/cpu_debug_cmd_scheduler.sv
// Queues JTAG take_action strobes into an ordered command FIFO and replays them
// on the debug bus with an auto-incrementing OCI address and sticky error flags.
module cpu_debug_cmd_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [37:0]               jdo,
    input  logic                      take_action_ocimem_a,
    input  logic                      take_action_ocimem_b,
    input  logic                      take_no_action_ocimem_a,
    input  logic                      take_action_tracemem_a,
    input  logic                      clr_err,
    cpu_debug_cmd_scheduler_if.master bus,
    output logic                      rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      busy,
    output logic                      err_overflow,
    output logic                      err_collide,
    output logic                      err_timeout
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = DATA_W + 2;
    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PTR_W:0] PTR_ONE = 1;

    localparam logic [1:0] CMD_SETADDR = 2'd0;
    localparam logic [1:0] CMD_WRITE   = 2'd1;
    localparam logic [1:0] CMD_READ    = 2'd2;
    localparam logic [1:0] CMD_TRACE   = 2'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

    state_e              state_reg, state_next;
    logic [PTR_W:0]      wr_ptr_reg, rd_ptr_reg;
    logic [ENTRY_W-1:0]  entry_q [FIFO_DEPTH];
    logic [1:0]          cmd_type_reg, head_type, push_type;
    logic [DATA_W-1:0]   cmd_data_reg, head_data, push_data, rd_data_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [CNT_W-1:0]    wait_cnt_reg;
    logic                err_overflow_reg, err_collide_reg, err_timeout_reg;
    logic                push_req, push_ok, pop, fifo_empty, fifo_full;
    logic                collide, overflow_evt;
    logic                load_addr, load_cmd, inc_addr, cap_rd, timeout_evt;
    logic                unused_jdo;

    assign unused_jdo = ^jdo;

    // Strobe arbitration: a single winner per cycle, losers only flag a collision.
    always_comb begin
        push_req  = 1'b1;
        push_type = CMD_WRITE;
        push_data = jdo[3 +: DATA_W];
        if (take_action_ocimem_b) begin
            push_type = CMD_WRITE;
        end else if (take_action_ocimem_a) begin
            push_type = CMD_SETADDR;
            push_data = DATA_W'(jdo[17 +: ADDR_W]);
        end else if (take_no_action_ocimem_a) begin
            push_type = CMD_READ;
            push_data = '0;
        end else if (take_action_tracemem_a) begin
            push_type = CMD_TRACE;
            push_data = '0;
        end else begin
            push_req  = 1'b0;
        end
    end

    assign collide = $countones({take_action_ocimem_a, take_action_ocimem_b,
                                 take_no_action_ocimem_a, take_action_tracemem_a}) > 1;

    assign fifo_empty   = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                          (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok      = push_req && (!fifo_full || pop);
    assign overflow_evt = push_req && fifo_full && !pop;
    assign {head_type, head_data} = entry_q[rd_ptr_reg[PTR_W-1:0]];

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [ENTRY_W-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    entry_reg <= '0;
                end else if (push_ok && (wr_ptr_reg[PTR_W-1:0] == PTR_W'(gi))) begin
                    entry_reg <= {push_type, push_data};
                end
            end
            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        pop         = 1'b0;
        load_addr   = 1'b0;
        load_cmd    = 1'b0;
        inc_addr    = 1'b0;
        cap_rd      = 1'b0;
        timeout_evt = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_type == CMD_SETADDR) begin
                        load_addr = 1'b1;
                    end else begin
                        load_cmd   = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (bus.ack) begin
                    state_next = RESP;
                    inc_addr   = 1'b1;
                    cap_rd     = (cmd_type_reg == CMD_READ) || (cmd_type_reg == CMD_TRACE);
                end else if (wait_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    state_next  = IDLE;
                    timeout_evt = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            addr_reg         <= '0;
            cmd_type_reg     <= '0;
            cmd_data_reg     <= '0;
            wait_cnt_reg     <= '0;
            rd_data_reg      <= '0;
            err_overflow_reg <= 1'b0;
            err_collide_reg  <= 1'b0;
            err_timeout_reg  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            if (load_addr)     addr_reg <= head_data[ADDR_W-1:0];
            else if (inc_addr) addr_reg <= addr_reg + ADDR_W'(1);
            if (load_cmd) begin
                cmd_type_reg <= head_type;
                cmd_data_reg <= head_data;
                wait_cnt_reg <= '0;
            end else if (state_reg == ISSUE) begin
                wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
            end
            if (cap_rd) rd_data_reg <= bus.rdata;
            // A fresh error event outranks a simultaneous clear.
            err_overflow_reg <= overflow_evt | (err_overflow_reg & ~clr_err);
            err_collide_reg  <= collide      | (err_collide_reg  & ~clr_err);
            err_timeout_reg  <= timeout_evt  | (err_timeout_reg  & ~clr_err);
        end
    end

    assign bus.req      = (state_reg == ISSUE);
    assign bus.we       = (state_reg == ISSUE) && (cmd_type_reg == CMD_WRITE);
    assign bus.sel      = (state_reg == ISSUE) && (cmd_type_reg == CMD_TRACE);
    assign bus.addr     = addr_reg;
    assign bus.wdata    = cmd_data_reg;
    assign rd_valid     = (state_reg == RESP) &&
                          ((cmd_type_reg == CMD_READ) || (cmd_type_reg == CMD_TRACE));
    assign rd_data      = rd_data_reg;
    assign busy         = (state_reg != IDLE) || !fifo_empty;
    assign err_overflow = err_overflow_reg;
    assign err_collide  = err_collide_reg;
    assign err_timeout  = err_timeout_reg;
endmodule
